// File: rtl/snn_config_loader.sv
// snn_config_loader
// Byte-serial configuration writer for the three-neuron spiking layer.
// A 13-byte frame is staged internally and then committed in one edge to the
// weight and parameter buses. The layer therefore only ever sees a complete,
// previously committed configuration. The layer update enable stays gated
// until the first commit has happened.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; ready low, incoming bytes ignored
// S_LOAD   | accepting bytes into staging; start here restarts the frame
// S_COMMIT | single cycle: staging copied to outputs, done pulses
module snn_config_loader #(
    parameter int WEIGHT_BYTES = 9,
    parameter int PARAM_BYTES  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid,
    output logic                      ready,
    input  logic                      enable_in,
    output logic                      layer_enable,
    output logic [8*WEIGHT_BYTES-1:0] input_weights,
    output logic [8*PARAM_BYTES-1:0]  neuron_params,
    output logic                      config_valid,
    output logic                      done,
    output logic                      frame_error,
    output logic [3:0]                byte_count
);

    localparam int WW    = 8 * WEIGHT_BYTES;
    localparam int PW    = 8 * PARAM_BYTES;
    localparam int TOTAL = WEIGHT_BYTES + PARAM_BYTES;
    localparam logic [3:0] LAST_IDX = 4'(TOTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t          r_state;
    logic [WW-1:0]   r_stage_w;
    logic [PW-1:0]   r_stage_p;
    logic [WW-1:0]   r_weights;
    logic [PW-1:0]   r_params;
    logic            r_cfg_valid;
    logic            r_done;
    logic            r_frame_error;
    logic            r_ready;
    logic [3:0]      r_byte_count;
    logic            w_accept;

    // A byte presented together with a restart is dropped, so start wins.
    assign w_accept = (r_state == S_LOAD) & byte_valid & ~start;

    // Staging capture: byte slot is the current count, first byte in the MSBs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stage_w <= '0;
            r_stage_p <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < WEIGHT_BYTES; k++) begin
                if (r_byte_count == 4'(k)) begin
                    r_stage_w[WW-1-8*k -: 8] <= byte_in;
                end
            end
            for (int k = 0; k < PARAM_BYTES; k++) begin
                if (r_byte_count == 4'(WEIGHT_BYTES + k)) begin
                    r_stage_p[PW-1-8*k -: 8] <= byte_in;
                end
            end
        end
    end

    // Frame sequencing, byte counting, commit and the one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_weights     <= '0;
            r_params      <= '0;
            r_cfg_valid   <= 1'b0;
            r_done        <= 1'b0;
            r_frame_error <= 1'b0;
            r_ready       <= 1'b0;
            r_byte_count  <= 4'd0;
        end else begin
            r_done        <= 1'b0;
            r_frame_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_LOAD;
                        r_byte_count <= 4'd0;
                        r_ready      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (start) begin
                        r_byte_count  <= 4'd0;
                        r_frame_error <= 1'b1;
                    end else if (byte_valid) begin
                        r_byte_count <= r_byte_count + 4'd1;
                        if (r_byte_count == LAST_IDX) begin
                            r_state <= S_COMMIT;
                            r_ready <= 1'b0;
                        end
                    end
                end
                S_COMMIT: begin
                    r_weights    <= r_stage_w;
                    r_params     <= r_stage_p;
                    r_cfg_valid  <= 1'b1;
                    r_done       <= 1'b1;
                    r_byte_count <= 4'd0;
                    r_ready      <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_ready      <= 1'b0;
                    r_byte_count <= 4'd0;
                end
            endcase
        end
    end

    assign ready         = r_ready;
    assign input_weights = r_weights;
    assign neuron_params = r_params;
    assign config_valid  = r_cfg_valid;
    assign done          = r_done;
    assign frame_error   = r_frame_error;
    assign byte_count    = r_byte_count;
    assign layer_enable  = enable_in & r_cfg_valid;

endmodule

// File: tb/tb_snn_config_loader.sv
// Bench for snn_config_loader: a driver issues frames and pushes the expected
// committed configuration into a queue; an independent monitor pops it on
// every done pulse and tracks what the committed outputs must be each cycle.
module tb_snn_config_loader;

    typedef struct {
        logic [71:0] w;
        logic [31:0] p;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        ready;
    logic        enable_in = 1'b1;
    logic        layer_enable;
    logic [71:0] input_weights;
    logic [31:0] neuron_params;
    logic        config_valid;
    logic        done;
    logic        frame_error;
    logic [3:0]  byte_count;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_err = 0;
    int   err_seen = 0;
    exp_t exp_q[$];

    logic [71:0] cur_w = '0;
    logic [31:0] cur_p = '0;
    logic        cur_v = 1'b0;
    logic        pend_rst = 1'b1;

    always #5 clk = ~clk;

    snn_config_loader #(.WEIGHT_BYTES(9), .PARAM_BYTES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .ready        (ready),
        .enable_in    (enable_in),
        .layer_enable (layer_enable),
        .input_weights(input_weights),
        .neuron_params(neuron_params),
        .config_valid (config_valid),
        .done         (done),
        .frame_error  (frame_error),
        .byte_count   (byte_count)
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference packing: first byte most significant, plain shift-and-or.
    function automatic exp_t pack(input logic [7:0] b[13]);
        exp_t e;
        e.w = '0;
        e.p = '0;
        for (int k = 0; k < 9; k++)  e.w = (e.w << 8) | 72'(b[k]);
        for (int k = 9; k < 13; k++) e.p = (e.p << 8) | 32'(b[k]);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) enable_in = 1'($urandom_range(0, 1));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_weights"}, input_weights, 72'd0);
        chk({tag, "_params"},  72'(neuron_params), 72'd0);
        chk({tag, "_cfg"},     72'(config_valid), 72'd0);
        chk({tag, "_ready"},   72'(ready), 72'd0);
        chk({tag, "_count"},   72'(byte_count), 72'd0);
        chk({tag, "_done"},    72'(done), 72'd0);
        chk({tag, "_ferr"},    72'(frame_error), 72'd0);
        chk({tag, "_len"},     72'(layer_enable), 72'd0);
    endtask

    task automatic send_frame(input logic [7:0] fr[13], input int max_gap,
                              input bit do_start, input bit start_in_commit);
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("ready_after_start", 72'(ready), 72'd1);
            chk("count_after_start", 72'(byte_count), 72'd0);
        end
        for (int k = 0; k < 13; k++) begin
            int g;
            g = $urandom_range(0, max_gap);
            repeat (g) begin
                byte_valid = 1'b0;
                byte_in = 8'($urandom);
                tick();
                chk("ready_stall", 72'(ready), 72'd1);
                chk("count_stall", 72'(byte_count), 72'(k));
            end
            byte_valid = 1'b1;
            byte_in = fr[k];
            if (k == 12) exp_q.push_back(pack(fr));
            tick();
            byte_valid = 1'b0;
            if (k < 12) chk("count_load", 72'(byte_count), 72'(k + 1));
        end
        chk("commit_ready", 72'(ready), 72'd0);
        chk("commit_count", 72'(byte_count), 72'd13);
        chk("commit_done_early", 72'(done), 72'd0);
        byte_valid = 1'b1;
        byte_in = 8'hEE;
        if (start_in_commit) start = 1'b1;
        tick();
        start = 1'b0;
        byte_valid = 1'b0;
        chk("done_pulse", 72'(done), 72'd1);
        chk("idle_ready", 72'(ready), 72'd0);
        chk("idle_count", 72'(byte_count), 72'd0);
        chk("no_ferr_commit", 72'(frame_error), 72'd0);
        tick();
        chk("done_single", 72'(done), 72'd0);
        chk("idle_ready2", 72'(ready), 72'd0);
        chk("no_ferr_idle", 72'(frame_error), 72'd0);
    endtask

    // Monitor: tracks committed configuration and checks outputs every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pend_rst) begin
                cur_w = '0;
                cur_p = '0;
                cur_v = 1'b0;
                exp_q.delete();
            end
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 72'(done), 72'd0);
                end else begin
                    e = exp_q.pop_front();
                    cur_w = e.w;
                    cur_p = e.p;
                    cur_v = 1'b1;
                end
            end
            chk("mon_weights", input_weights, cur_w);
            chk("mon_params", 72'(neuron_params), 72'(cur_p));
            chk("mon_cfg", 72'(config_valid), 72'(cur_v));
            chk("mon_layer_en", 72'(layer_enable), 72'(enable_in & cur_v));
            if (frame_error === 1'b1) err_seen++;
            pend_rst = !rst_n;
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] fr[13];

        // Reset with the raw enable high.
        rst_n = 1'b0;
        enable_in = 1'b1;
        tick();
        tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        // Fixed frame 0x01..0x0D, back-to-back.
        for (int k = 0; k < 13; k++) fr[k] = 8'(k + 1);
        send_frame(fr, 0, 1'b1, 1'b0);
        chk("full_weights", input_weights, 72'h010203040506070809);
        chk("full_params", 72'(neuron_params), 72'h0A0B0C0D);

        // Bytes offered in IDLE are ignored, then a stalled frame.
        repeat (3) begin
            byte_valid = 1'b1;
            byte_in = 8'($urandom);
            tick();
            chk("idle_ignore_ready", 72'(ready), 72'd0);
            chk("idle_ignore_count", 72'(byte_count), 72'd0);
        end
        byte_valid = 1'b0;
        for (int k = 0; k < 13; k++) fr[k] = 8'(8'hF0 + k);
        send_frame(fr, 3, 1'b1, 1'b0);
        chk("stall_weights", input_weights, 72'hF0F1F2F3F4F5F6F7F8);
        chk("stall_params", 72'(neuron_params), 72'hF9FAFBFC);

        // Restart: commit all 0x11, abort after 5 bytes, then all 0x22.
        for (int k = 0; k < 13; k++) fr[k] = 8'h11;
        send_frame(fr, 1, 1'b1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) begin
            byte_valid = 1'b1;
            byte_in = 8'h55;
            tick();
        end
        start = 1'b1;
        byte_valid = 1'b1;
        byte_in = 8'h99;
        exp_err++;
        tick();
        start = 1'b0;
        byte_valid = 1'b0;
        chk("restart_ferr", 72'(frame_error), 72'd1);
        chk("restart_count", 72'(byte_count), 72'd0);
        chk("restart_ready", 72'(ready), 72'd1);
        chk("restart_keep", input_weights, {9{8'h11}});
        tick();
        chk("restart_ferr_single", 72'(frame_error), 72'd0);
        for (int k = 0; k < 13; k++) fr[k] = 8'h22;
        send_frame(fr, 2, 1'b0, 1'b0);
        chk("restart_weights", input_weights, {9{8'h22}});
        chk("restart_params", 72'(neuron_params), 72'h22222222);

        // Reset in the middle of a frame.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) begin
            byte_valid = 1'b1;
            byte_in = 8'($urandom);
            tick();
        end
        byte_valid = 1'b0;
        rst_n = 1'b0;
        enable_in = 1'b1;
        tick();
        tick();
        chk_zero("midreset");
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 13; k++) fr[k] = 8'($urandom);
        send_frame(fr, 2, 1'b1, 1'b0);
        chk("after_reset_cfg", 72'(config_valid), 72'd1);

        // Random frames; one carries a start during the commit cycle.
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 13; k++) fr[k] = 8'($urandom);
            send_frame(fr, $urandom_range(0, 3), 1'b1, (i == 2));
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        tick();
        chk("queue_drained", 72'(exp_q.size()), 72'd0);
        chk("ferr_count", 72'(err_seen), 72'(exp_err));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/snn_config_loader.md
# snn_config_loader

Byte-serial configuration writer for the three-neuron spiking layer. It accepts a framed stream of 13 bytes on a narrow pin interface, which suits the tile's limited I/O. It stages the bytes internally, then commits them atomically to the 72-bit `input_weights` and 32-bit `neuron_params` buses that drive the layer. While a new frame loads, the layer keeps seeing a coherent, previously committed configuration, and the layer's update enable is gated until a first valid configuration exists.

## Interface
Parameters:
- `WEIGHT_BYTES`, 9: number of weight bytes per frame (3 neurons × 3 inputs).
- `PARAM_BYTES`, 4: number of parameter bytes per frame (threshold, decay, refractory_period, feedback_scale).

Ports:
- `clk` input 1: single clock; all logic rises on its edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `start` input 1: frame start strobe, one cycle.
- `byte_in` input 8: configuration byte.
- `byte_valid` input 1: `byte_in` is valid this cycle.
- `ready` output 1: loader accepts a byte this cycle.
- `enable_in` input 1: raw layer update enable.
- `layer_enable` output 1: `enable_in & config_valid`, combinational.
- `input_weights` output 72: committed weights, same packing the layer expects.
- `neuron_params` output 32: committed `{threshold, decay, refractory_period, feedback_scale}`.
- `config_valid` output 1: at least one frame has been committed since reset.
- `done` output 1: one-cycle pulse on commit.
- `frame_error` output 1: one-cycle pulse when a frame is aborted by a restart.
- `byte_count` output 4: bytes accepted in the current frame.

## Operation
- FSM states: IDLE, LOAD, COMMIT.
- IDLE:
  - `ready`=0; `byte_valid` is ignored.
  - `start`=1 → LOAD, `byte_count`←0.
- LOAD:
  - `ready`=1.
  - A byte is accepted when `byte_valid & ready`. It is written to staging slot `byte_count`, then `byte_count`++.
  - Byte k (0..8) → staging weights bits [71-8k : 64-8k]. Byte 0 is `weight1_0` at [71:64]; byte 8 is `weight3_2` at [7:0].
  - Byte 9+j (j=0..3) → staging params bits [31-8j : 24-8j]. Byte 9 is threshold; byte 12 is feedback_scale.
  - Acceptance of the last byte (`byte_count`==12) → COMMIT.
  - `start`=1 in LOAD, with or without `byte_valid`: restart. `byte_count`←0, `frame_error` pulses, state stays LOAD, and any byte presented that cycle is dropped. Staging contents are not cleared; they are overwritten by the new frame.
- COMMIT (exactly one cycle):
  - `ready`=0.
  - Staging is copied to `input_weights`/`neuron_params`; `config_valid`←1; `done` pulses; → IDLE.
  - `start` in COMMIT is ignored.
- Committed outputs change only on a commit edge. Staging writes never reach the outputs directly.
- `config_valid` stays 1 until reset.
- No arithmetic; bytes are passed through unaltered. Sign interpretation belongs to the layer.

## Timing
- Reset (`rst_n`=0 at a clock edge) forces:
  - state IDLE;
  - `input_weights`=0, `neuron_params`=0, staging=0;
  - `config_valid`=0, `done`=0, `frame_error`=0, `byte_count`=0, `ready`=0;
  - `layer_enable`=0.
- Reset mid-frame discards the frame; there is no commit and no `done`.
- `start` sampled at edge t → `ready`=1 from cycle t+1.
- Throughput: one byte per cycle; minimum frame time is 13 cycles.
- Last byte accepted at edge t:
  - COMMIT during cycle t+1 (`ready`=0, `byte_valid` ignored);
  - at edge t+1, outputs update, `done`=1, and `config_valid`=1 during cycle t+2;
  - IDLE from cycle t+2.
- Stalls: `byte_valid`=0 in LOAD holds state indefinitely; there is no timeout.
- `frame_error` is registered: `start` at edge t in LOAD → `frame_error`=1 during cycle t+1.
- `byte_count` is registered and reflects accepted bytes; it reads 13 during COMMIT and 0 after returning to IDLE.

## Test plan
- Reset check: hold `rst_n`=0 for 2 cycles with `enable_in`=1 → all outputs 0, including `layer_enable`=0.
- Full frame: `start`, then bytes 0x01..0x0D back-to-back →
  - `input_weights`=72'h010203040506070809, `neuron_params`=32'h0A0B0C0D;
  - `done` is high exactly one cycle, two cycles after the last byte edge;
  - `config_valid`=1 and `layer_enable` follows `enable_in`.
- Stalled frame: bytes 0xF0..0xFC with random `byte_valid` gaps, plus `byte_valid` pulses in IDLE before `start` → identical packing to the gap-free case; IDLE bytes are not captured.
- Restart: first frame 0x11 committed. Second frame: send 5 bytes, pulse `start`, then send 13 bytes of 0x22 →
  - `frame_error` pulses once;
  - outputs stay all-0x11 until commit, then become all-0x22.
- Reset mid-frame: after a committed frame A, send 7 bytes of frame B, then assert `rst_n`=0 →
  - all outputs 0 and `config_valid`=0;
  - a subsequent full frame commits normally.
- COMMIT-cycle `start`: pulse `start` during the COMMIT cycle → ignored, no `frame_error`; the loader is in IDLE with `ready`=0.
